snitch_icache_perf_cnt: RTL and testbench
=========================================

SNITCH_ICACHE_PERF_CNT -- requirements
Module: snitch_icache_perf_cnt

Interface
REQ-001 SHALL have parameter NR_FETCH_PORTS, default 2: number of L0 fetch ports whose events are counted; legal range 1..32.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of every counter; legal range 8..64.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port events_i  input  NR_FETCH_PORTS x icache_events_t  per-port L0 event pulses, one cycle each.
REQ-006 SHALL have port enable_i  input  1  counting enable.
REQ-007 SHALL have port clear_i  input  1  zero live counters.
REQ-008 SHALL have port snapshot_i  input  1  copy live counters into shadow registers.
REQ-009 SHALL have port rd_req_i  input  1  read request, always accepted.
REQ-010 SHALL have port rd_addr_i  input  2  shadow select: 0 miss, 1 hit, 2 prefetch, 3 double_hit.
REQ-011 SHALL have port rd_valid_o  output  1  read data valid.
REQ-012 SHALL have port rd_data_o  output  CNT_WIDTH  shadow counter value.
REQ-013 SHALL have port irq_o  output  1  overflow interrupt, level.

Function
REQ-014 Four live counters SHALL exist, one per event field (miss, hit, prefetch, double_hit).
REQ-015 Per cycle with enable_i=1, each live counter SHALL add the count of ports asserting its field that cycle (0..NR_FETCH_PORTS), result visible next cycle.
REQ-016 Increment width SHALL be clog2(NR_FETCH_PORTS+1) bits, zero-extended; addition SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-017 With enable_i=0 live counters SHALL hold; events SHALL be discarded, not deferred.
REQ-018 clear_i=1 SHALL set all live counters to 0 next cycle; clear SHALL win over same-cycle increments (those events lost).
REQ-019 snapshot_i=1 SHALL load all four shadows with live values as registered before this cycle's update (pre-increment, pre-clear).
REQ-020 snapshot_i and clear_i together SHALL give atomic read-and-clear: shadows get pre-clear values, live counters become 0.
REQ-021 rd_req_i=1 in cycle N SHALL give rd_valid_o=1 and rd_data_o=shadow[rd_addr_i sampled at N] in cycle N+1; back-to-back reads SHALL be supported every cycle.
REQ-022 Read at N with snapshot at N SHALL return the pre-snapshot shadow value.
REQ-023 rd_data_o SHALL be 0 whenever rd_valid_o=0.

Reset
REQ-024 rst_ni low SHALL asynchronously zero live counters, shadows, overflow flags, rd_valid_o, rd_data_o, irq_o.
REQ-025 Reset mid-operation SHALL drop any in-flight read response; first valid read after deassertion SHALL return 0.

Configuration
REQ-026 Macro SNITCH_ICACHE_PERF_OVF_IRQ_EN SHALL control overflow interrupt.
REQ-027 Defined: per-counter sticky flag SHALL set in the cycle an increment is clipped by saturation; irq_o SHALL be registered OR of flags (asserts one cycle after flag set); clear_i SHALL clear flags, clear winning over same-cycle set.
REQ-028 Undefined: no flag registers SHALL be built, irq_o SHALL be constant 0; saturation SHALL still apply.

Structure
REQ-029 icache_events_t SHALL be taken from snitch_icache_pkg; perf counter address enum (4 entries) SHALL be added to snitch_icache_pkg.
REQ-030 One sub-module snitch_icache_perf_popcnt (NR_FETCH_PORTS bits in, clog2(NR_FETCH_PORTS+1) out, combinational) SHALL be instantiated per event field.

Verification
REQ-031 NR_FETCH_PORTS=2, enable=1, both ports hit for 10 cycles, then snapshot, read addr 1 -> rd_data_o=20 one cycle after request.
REQ-032 CNT_WIDTH=8, miss counter preloaded to 254 via 127 double-port cycles, then 2 more double-port misses -> counter 255 held; with macro irq_o=1 one cycle after clip; without, irq_o stays 0.
REQ-033 Counter=7, same cycle clear+snapshot+one hit -> shadow=7, live=0 next cycle, the hit is lost.
REQ-034 enable=0 with events on all ports for 5 cycles -> all counters unchanged.
REQ-035 Reads at addr 0,1,2,3 on consecutive cycles -> four consecutive valid responses in order, rd_valid_o high 4 cycles.
REQ-036 rst_ni asserted while rd_req_i pending -> rd_valid_o=0 immediately, all counters and irq_o 0 after release.

Source files
------------

// File: rtl/snitch_icache_pkg.sv
// Shared types for the Snitch instruction cache.
//
// icache_events_t : one-cycle event pulses raised by each L0 fetch port.
//                   Bit order, MSB to LSB: miss, hit, prefetch, double_hit.
// perf_addr_e     : selects which performance shadow counter is read back.
package snitch_icache_pkg;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
  } icache_events_t;

  localparam int unsigned NR_PERF_CNT = 4;

  typedef enum logic [1:0] {
    PERF_MISS       = 2'd0,
    PERF_HIT        = 2'd1,
    PERF_PREFETCH   = 2'd2,
    PERF_DOUBLE_HIT = 2'd3
  } perf_addr_e;

endpackage

// File: rtl/snitch_icache_perf_popcnt.sv
// Population count of one event field across all fetch ports.
//
// Parameters : NR_FETCH_PORTS - number of input bits
// Ports      : bits_i - one event bit per port
//              cnt_o  - number of set bits, $clog2(NR_FETCH_PORTS+1) wide
// Purely combinational.
module snitch_icache_perf_popcnt #(
  parameter int unsigned NR_FETCH_PORTS = 2,
  localparam int unsigned OUT_W         = $clog2(NR_FETCH_PORTS + 1)
) (
  input  logic [NR_FETCH_PORTS-1:0] bits_i,
  output logic [OUT_W-1:0]          cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NR_FETCH_PORTS; i++) begin
      cnt_o = cnt_o + OUT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/snitch_icache_perf_cnt.sv
// L0 instruction-cache performance counters.
//
// Four saturating live counters (miss, hit, prefetch, double_hit) accumulate
// the number of fetch ports raising each event per enabled cycle. A snapshot
// copies the live counters into shadow registers, which are read back with a
// one-cycle registered response.
//
// Parameters : NR_FETCH_PORTS (1..32), CNT_WIDTH (8..64)
// Ports      : clk_i, rst_ni (async, active-low)
//              events_i   - per-port event pulses
//              enable_i   - count enable; events are dropped while low
//              clear_i    - zero live counters (and overflow flags)
//              snapshot_i - copy pre-update live values into shadows
//              rd_req_i / rd_addr_i   - read request, always accepted
//              rd_valid_o / rd_data_o - response one cycle later, data 0 when idle
//              irq_o      - level overflow interrupt
//
// Build option: define SNITCH_ICACHE_PERF_OVF_IRQ_EN to build sticky overflow
// flags and drive irq_o; otherwise irq_o is tied to 0 (saturation still applies).
module snitch_icache_perf_cnt
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  icache_events_t [NR_FETCH_PORTS-1:0]  events_i,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  logic                                 snapshot_i,
  input  logic                                 rd_req_i,
  input  logic [1:0]                           rd_addr_i,
  output logic                                 rd_valid_o,
  output logic [CNT_WIDTH-1:0]                 rd_data_o,
  output logic                                 irq_o
);

  localparam int unsigned INC_W = $clog2(NR_FETCH_PORTS + 1);
  localparam int unsigned SUM_W = CNT_WIDTH + 1;

  function automatic logic [SUM_W-1:0] wide_sum(input logic [CNT_WIDTH-1:0] cnt,
                                                input logic [INC_W-1:0]     inc);
    return {1'b0, cnt} + SUM_W'(inc);
  endfunction

  // Clamp to all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [INC_W-1:0]     inc);
    logic [SUM_W-1:0] sum;
    sum = wide_sum(cnt, inc);
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  // True when the increment would have carried past the counter width.
  function automatic logic sat_clip(input logic [CNT_WIDTH-1:0] cnt,
                                    input logic [INC_W-1:0]     inc);
    logic [SUM_W-1:0] sum;
    sum = wide_sum(cnt, inc);
    return sum[CNT_WIDTH];
  endfunction

  logic [NR_PERF_CNT-1:0][NR_FETCH_PORTS-1:0] ev_vec_p0;
  logic [INC_W-1:0]     inc_p0    [NR_PERF_CNT];
  logic [CNT_WIDTH-1:0] cnt_p1    [NR_PERF_CNT];
  logic [CNT_WIDTH-1:0] shadow_p1 [NR_PERF_CNT];
  logic                 vld_p1;
  logic [CNT_WIDTH-1:0] data_p1;

  // Transpose port-major events into field-major vectors.
  always_comb begin
    ev_vec_p0 = '0;
    for (int p = 0; p < NR_FETCH_PORTS; p++) begin
      ev_vec_p0[PERF_MISS][p]       = events_i[p].l0_miss;
      ev_vec_p0[PERF_HIT][p]        = events_i[p].l0_hit;
      ev_vec_p0[PERF_PREFETCH][p]   = events_i[p].l0_prefetch;
      ev_vec_p0[PERF_DOUBLE_HIT][p] = events_i[p].l0_double_hit;
    end
  end

  for (genvar f = 0; f < NR_PERF_CNT; f++) begin : gen_popcnt
    snitch_icache_perf_popcnt #(
      .NR_FETCH_PORTS (NR_FETCH_PORTS)
    ) i_popcnt (
      .bits_i (ev_vec_p0[f]),
      .cnt_o  (inc_p0[f])
    );
  end

  // ---- p0 -> p1: live counters, shadows, read response ----
  // Shadows sample cnt_p1 before this edge's update, so a snapshot taken
  // together with clear captures the pre-clear values atomically.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int f = 0; f < NR_PERF_CNT; f++) begin
        cnt_p1[f]    <= '0;
        shadow_p1[f] <= '0;
      end
    end else begin
      for (int f = 0; f < NR_PERF_CNT; f++) begin
        if (clear_i) begin
          cnt_p1[f] <= '0;
        end else if (enable_i) begin
          cnt_p1[f] <= sat_add(cnt_p1[f], inc_p0[f]);
        end
        if (snapshot_i) begin
          shadow_p1[f] <= cnt_p1[f];
        end
      end
    end
  end

  // The mux reads the shadow before any same-cycle snapshot lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= rd_req_i;
      data_p1 <= rd_req_i ? shadow_p1[rd_addr_i] : '0;
    end
  end

  assign rd_valid_o = vld_p1;
  assign rd_data_o  = data_p1;

`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
  logic [NR_PERF_CNT-1:0] ovf_p1;
  logic                   irq_p2;

  // Sticky per-counter flags; clear has priority over a same-cycle clip.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_p1 <= '0;
    end else if (clear_i) begin
      ovf_p1 <= '0;
    end else if (enable_i) begin
      for (int f = 0; f < NR_PERF_CNT; f++) begin
        if (sat_clip(cnt_p1[f], inc_p0[f])) begin
          ovf_p1[f] <= 1'b1;
        end
      end
    end
  end

  // ---- p1 -> p2: registered interrupt ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_p2 <= 1'b0;
    end else begin
      irq_p2 <= |ovf_p1;
    end
  end

  assign irq_o = irq_p2;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
module tb_snitch_icache_perf_cnt;
  import snitch_icache_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned CW = 8;
`ifdef SNITCH_ICACHE_PERF_OVF_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic                      clk_i;
  logic                      rst_ni;
  icache_events_t [NP-1:0]   events_i;
  logic                      enable_i;
  logic                      clear_i;
  logic                      snapshot_i;
  logic                      rd_req_i;
  logic [1:0]                rd_addr_i;
  logic                      rd_valid_o;
  logic [CW-1:0]             rd_data_o;
  logic                      irq_o;

  snitch_icache_perf_cnt #(
    .NR_FETCH_PORTS (NP),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .events_i   (events_i),
    .enable_i   (enable_i),
    .clear_i    (clear_i),
    .snapshot_i (snapshot_i),
    .rd_req_i   (rd_req_i),
    .rd_addr_i  (rd_addr_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .irq_o      (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ev bits: {miss, hit, prefetch, double_hit}
  typedef struct {
    logic       en;
    logic       clr;
    logic       snap;
    logic [3:0] ev0;
    logic [3:0] ev1;
    logic       rd;
    logic [1:0] addr;
    logic       exp_vld;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [13];
  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic snap,
                       input logic [3:0] ev0, input logic [3:0] ev1,
                       input logic rd, input logic [1:0] addr);
    enable_i   = en;
    clear_i    = clr;
    snapshot_i = snap;
    events_i[0] = icache_events_t'(ev0);
    events_i[1] = icache_events_t'(ev1);
    rd_req_i   = rd;
    rd_addr_i  = addr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Snapshot live counters, then read one shadow; returns the response.
  task automatic snap_read(input logic [1:0] addr, output logic vld, output logic [CW-1:0] data);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, addr);
    cyc();
    vld  = rd_valid_o;
    data = rd_data_o;
    idle();
  endtask

  logic          v;
  logic [CW-1:0] d;

  initial begin
    n_vec = 0;
    n_err = 0;
    //          en    clr   snap  ev0      ev1      rd    addr  vld   data
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b0110, 1'b0, 2'd0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b0110, 1'b0, 2'd0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b0110, 1'b0, 2'd0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1, 8'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 2'd1, 1'b1, 8'd6};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 2'd2, 1'b1, 8'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 2'd3, 1'b1, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 2'd3, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1, 8'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b1, 8'd6};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b1, 8'd0};

    idle();
    rst_ni = 1'b0;
    repeat (3) cyc();
    chk("reset rd_valid", 64'(rd_valid_o), 64'd0);
    chk("reset rd_data", 64'(rd_data_o), 64'd0);
    chk("reset irq", 64'(irq_o), 64'd0);
    rst_ni = 1'b1;
    cyc();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].snap, vecs[i].ev0, vecs[i].ev1,
            vecs[i].rd, vecs[i].addr);
      cyc();
      chk($sformatf("vec%0d rd_valid", i), 64'(rd_valid_o), 64'(vecs[i].exp_vld));
      chk($sformatf("vec%0d rd_data", i), 64'(rd_data_o), 64'(vecs[i].exp_data));
    end
    idle();
    cyc();
    chk("idle rd_valid", 64'(rd_valid_o), 64'd0);
    chk("idle rd_data zero", 64'(rd_data_o), 64'd0);

    // Ten cycles of hits on both ports -> 20.
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0);
      cyc();
    end
    snap_read(2'd1, v, d);
    chk("hit20 rd_valid", 64'(v), 64'd1);
    chk("hit20 rd_data", 64'(d), 64'd20);

    // Counter at 7, then clear+snapshot+hit in one cycle.
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
    cyc();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0);
      cyc();
    end
    drive(1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd1);
    cyc();
    chk("rdclr shadow", 64'(rd_data_o), 64'd7);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1);
    cyc();
    chk("rdclr live zero", 64'(rd_data_o), 64'd0);
    idle();

    // Saturation: 127 double misses -> 254, then two more.
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
    cyc();
    for (int i = 0; i < 127; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0);
      cyc();
    end
    chk("pre-sat irq", 64'(irq_o), 64'd0);
    snap_read(2'd0, v, d);
    chk("miss 254", 64'(d), 64'd254);
    drive(1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0);
    cyc();
    chk("clip cycle irq", 64'(irq_o), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0);
    cyc();
    chk("irq after clip", 64'(irq_o), 64'(IRQ_EN));
    snap_read(2'd0, v, d);
    chk("miss saturated", 64'(d), 64'd255);
    chk("irq held", 64'(irq_o), 64'(IRQ_EN));

    // Asynchronous reset with a read in flight.
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0);
    cyc();
    chk("pre-reset rd_valid", 64'(rd_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async rd_valid", 64'(rd_valid_o), 64'd0);
    chk("async rd_data", 64'(rd_data_o), 64'd0);
    chk("async irq", 64'(irq_o), 64'd0);
    cyc();
    rst_ni = 1'b1;
    idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0);
    cyc();
    chk("post-reset first read", 64'(rd_data_o), 64'd0);
    idle();
    for (int a = 0; a < 4; a++) begin
      snap_read(2'(a), v, d);
      chk($sformatf("post-reset cnt%0d", a), 64'(d), 64'd0);
    end
    chk("post-reset irq", 64'(irq_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
